// File: rtl/mining_host.sv
// Host end of the UART mining link: streams a 128-byte job from local RAM into the UART
// transmitter, then assembles the returned 32-byte hash with done/timeout status.
`timescale 1ns/1ps

// state | meaning
// IDLE  | no job in flight; job RAM writable; done/timeout/hash hold last result
// SEND  | presenting RAM[idx] to the transmitter, advance on handshake
// WAIT  | all job bytes sent, waiting for first hash byte
// RECV  | collecting remaining hash bytes
module mining_host #(
    parameter int N          = 8,
    parameter int HDR_BYTES  = 128,
    parameter int HASH_BYTES = 32,
    parameter int TO_W       = 32
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         job_wr_i,
    input  logic [$clog2(HDR_BYTES)-1:0] job_addr_i,
    input  logic [N-1:0]                 job_data_i,
    input  logic                         start_i,
    input  logic                         abort_i,
    input  logic [TO_W-1:0]              timeout_i,
    output logic [N-1:0]                 tx_data_o,
    output logic                         tx_valid_o,
    input  logic                         tx_ready_i,
    input  logic [N-1:0]                 rx_data_i,
    input  logic                         rx_valid_i,
    output logic                         busy_o,
    output logic                         done_o,
    output logic                         timeout_o,
    output logic [N*HASH_BYTES-1:0]      hash_o
);

    localparam int AW = $clog2(HDR_BYTES);
    localparam int CW = $clog2(HASH_BYTES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2,
        RECV = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [AW-1:0]           idx_q, idx_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [TO_W-1:0]         to_cnt_q, to_cnt_d;
    logic [TO_W-1:0]         to_inc;
    logic                    to_hit;
    logic                    done_q, done_d;
    logic                    tout_q, tout_d;
    logic [N*HASH_BYTES-1:0] hash_q, hash_d;
    logic [N-1:0]            ram_q [HDR_BYTES];
    logic                    ram_we;

    // Job RAM holds no reset; writes only land while idle so a job in flight is never corrupted.
    assign ram_we = (state_q == IDLE) && job_wr_i;

    always_ff @(posedge clk_i) begin
        if (ram_we) begin
            ram_q[job_addr_i] <= job_data_i;
        end
    end

    assign to_inc = (&to_cnt_q) ? to_cnt_q : to_cnt_q + TO_W'(1);
    assign to_hit = (timeout_i != '0) && (to_inc >= timeout_i);

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        to_cnt_d = to_cnt_q;
        done_d   = done_q;
        tout_d   = tout_q;
        hash_d   = hash_q;
        if ((state_q != IDLE) && abort_i) begin
            state_d  = IDLE;
            idx_d    = '0;
            cnt_d    = '0;
            to_cnt_d = '0;
            done_d   = 1'b0;
            tout_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        state_d  = SEND;
                        idx_d    = '0;
                        cnt_d    = '0;
                        to_cnt_d = '0;
                        done_d   = 1'b0;
                        tout_d   = 1'b0;
                        hash_d   = '0;
                    end
                end
                SEND: begin
                    if (tx_ready_i) begin
                        idx_d = idx_q + AW'(1);
                        if (idx_q == AW'(HDR_BYTES - 1)) begin
                            state_d  = WAIT;
                            idx_d    = '0;
                            to_cnt_d = '0;
                        end
                    end
                end
                WAIT, RECV: begin
                    // A byte arriving on the terminal-count cycle wins over the timeout.
                    if (rx_valid_i) begin
                        hash_d[N*cnt_q +: N] = rx_data_i;
                        to_cnt_d = '0;
                        cnt_d    = cnt_q + CW'(1);
                        state_d  = RECV;
                        if (cnt_q == CW'(HASH_BYTES - 1)) begin
                            state_d = IDLE;
                            cnt_d   = '0;
                            done_d  = 1'b1;
                        end
                    end else begin
                        to_cnt_d = to_inc;
                        if (to_hit) begin
                            state_d = IDLE;
                            tout_d  = 1'b1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            cnt_q    <= '0;
            to_cnt_q <= '0;
            done_q   <= 1'b0;
            tout_q   <= 1'b0;
            hash_q   <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            to_cnt_q <= to_cnt_d;
            done_q   <= done_d;
            tout_q   <= tout_d;
            hash_q   <= hash_d;
        end
    end

    assign tx_valid_o = (state_q == SEND);
    assign tx_data_o  = tx_valid_o ? ram_q[idx_q] : '0;
    assign busy_o     = (state_q != IDLE);
    assign done_o     = done_q;
    assign timeout_o  = tout_q;
    assign hash_o     = hash_q;

endmodule

// File: tb/tb_mining_host.sv
// Bench for mining_host: transaction-level reference model compared every cycle, directed
// scenarios with literal expectations, then a long randomized run.
`timescale 1ns/1ps

module tb_mining_host;
    localparam int HB = 128;
    localparam int HS = 32;

    logic         clk = 1'b0;
    logic         rst_i = 1'b0;
    logic         job_wr_i = 1'b0;
    logic [6:0]   job_addr_i = '0;
    logic [7:0]   job_data_i = '0;
    logic         start_i = 1'b0;
    logic         abort_i = 1'b0;
    logic [31:0]  timeout_i = '0;
    logic [7:0]   tx_data_o;
    logic         tx_valid_o;
    logic         tx_ready_i = 1'b0;
    logic [7:0]   rx_data_i = '0;
    logic         rx_valid_i = 1'b0;
    logic         busy_o, done_o, timeout_o;
    logic [255:0] hash_o;

    int vectors = 0;
    int miscompares = 0;
    bit chk_on = 1'b0;

    mining_host dut (
        .clk_i(clk), .rst_i(rst_i),
        .job_wr_i(job_wr_i), .job_addr_i(job_addr_i), .job_data_i(job_data_i),
        .start_i(start_i), .abort_i(abort_i), .timeout_i(timeout_i),
        .tx_data_o(tx_data_o), .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready_i),
        .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i),
        .busy_o(busy_o), .done_o(done_o), .timeout_o(timeout_o), .hash_o(hash_o)
    );

    always #5 clk = ~clk;

    // Reference model: job progress tracked as counts and flags.
    logic [7:0]   mram [HB];
    bit           m_send = 0, m_await = 0, m_done = 0, m_tout = 0;
    int           m_sent = 0, m_got = 0;
    longint       m_idle = 0;
    logic [255:0] m_hash = '0;

    always @(posedge clk or negedge rst_i) begin
        if (!rst_i) begin
            m_send = 0; m_await = 0; m_done = 0; m_tout = 0;
            m_sent = 0; m_got = 0; m_idle = 0; m_hash = '0;
        end else if (m_send || m_await) begin
            if (abort_i) begin
                m_send = 0; m_await = 0; m_done = 0; m_tout = 0;
            end else if (m_send) begin
                if (tx_ready_i) begin
                    m_sent++;
                    if (m_sent == HB) begin
                        m_send = 0; m_await = 1; m_idle = 0;
                    end
                end
            end else if (rx_valid_i) begin
                m_hash[8*m_got +: 8] = rx_data_i;
                m_got++;
                m_idle = 0;
                if (m_got == HS) begin
                    m_await = 0; m_done = 1;
                end
            end else begin
                m_idle++;
                if (timeout_i != 0 && m_idle >= longint'({32'h0, timeout_i})) begin
                    m_await = 0; m_tout = 1;
                end
            end
        end else begin
            if (job_wr_i) mram[job_addr_i] = job_data_i;
            if (start_i) begin
                m_send = 1; m_sent = 0; m_got = 0; m_idle = 0;
                m_done = 0; m_tout = 0; m_hash = '0;
            end
        end
    end

    logic [7:0] exp_data;
    always @(negedge clk) begin
        if (chk_on) begin
            exp_data = m_send ? mram[m_sent] : 8'h00;
            vectors++;
            if (tx_valid_o !== m_send || tx_data_o !== exp_data || busy_o !== (m_send || m_await) ||
                done_o !== m_done || timeout_o !== m_tout || hash_o !== m_hash) begin
                miscompares++;
                $display("FAIL cycle t=%0t dut v=%b d=%h busy=%b done=%b to=%b hash=%h | model v=%b d=%h busy=%b done=%b to=%b hash=%h",
                         $time, tx_valid_o, tx_data_o, busy_o, done_o, timeout_o, hash_o,
                         m_send, exp_data, m_send || m_await, m_done, m_tout, m_hash);
            end
        end
    end

    // Handshake log taken mid-cycle, after inputs settle and before the next edge.
    logic [7:0] txlog [$];
    int         vcycles = 0;
    always @(negedge clk) begin
        #2;
        if (rst_i && tx_valid_o) begin
            vcycles++;
            if (tx_ready_i && !abort_i) txlog.push_back(tx_data_o);
        end
    end

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start_i = 1'b1;
        cyc();
        start_i = 1'b0;
    endtask

    task automatic load(input bit inverted);
        for (int i = 0; i < HB; i++) begin
            job_wr_i   = 1'b1;
            job_addr_i = 7'(i);
            job_data_i = inverted ? 8'(255 - i) : 8'(i);
            cyc();
        end
        job_wr_i = 1'b0;
    endtask

    task automatic wait_rx_phase(input string name);
        int k = 0;
        while (!(busy_o && !tx_valid_o) && k < 2000) begin
            cyc();
            k++;
        end
        if (k >= 2000) begin
            miscompares++;
            $display("FAIL %s: no wait-for-hash phase within 2000 cycles", name);
        end
    endtask

    task automatic send_rx(input logic [7:0] b);
        rx_valid_i = 1'b1;
        rx_data_i  = b;
        cyc();
        rx_valid_i = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int errs;
        int k;
        repeat (3) cyc();
        rst_i = 1'b1;
        cyc();
        chk_on = 1'b1;
        check("reset_busy", busy_o, 0);
        check("reset_hash", hash_o, 0);
        check("reset_txv", tx_valid_o, 0);

        // Sequential job bytes, transmitter always ready.
        tx_ready_i = 1'b1;
        load(1'b0);
        txlog.delete();
        vcycles = 0;
        pulse_start();
        wait_rx_phase("t1_wait");
        check("t1_valid_cycles", vcycles, 128);
        check("t1_count", txlog.size(), 128);
        errs = 0;
        foreach (txlog[i]) if (txlog[i] !== 8'(i)) errs++;
        check("t1_order", errs, 0);

        // Hash bytes 0x01..0x20 with small random gaps.
        for (int b = 1; b <= 32; b++) begin
            send_rx(8'(b));
            repeat ($urandom_range(0, 2)) cyc();
        end
        check("t3_byte0", hash_o[7:0], 8'h01);
        check("t3_byte31", hash_o[255:248], 8'h20);
        check("t3_done", done_o, 1);
        check("t3_busy", busy_o, 0);

        // Transmitter stalls in 3-cycle windows.
        load(1'b1);
        txlog.delete();
        tx_ready_i = 1'b0;
        pulse_start();
        k = 0;
        while (!(busy_o && !tx_valid_o) && k < 2000) begin
            tx_ready_i = ((k / 3) % 2) == 1;
            cyc();
            k++;
        end
        tx_ready_i = 1'b1;
        check("t2_count", txlog.size(), 128);
        errs = 0;
        foreach (txlog[i]) if (txlog[i] !== 8'(255 - i)) errs++;
        check("t2_order", errs, 0);

        // Five bytes then silence against a 100-cycle timeout.
        timeout_i = 32'd100;
        for (int b = 0; b < 5; b++) send_rx(8'(8'hA1 + b));
        k = 0;
        while (!timeout_o && k < 300) begin
            cyc();
            k++;
        end
        check("t4_delay", k, 100);
        check("t4_done", done_o, 0);
        check("t4_busy", busy_o, 0);
        check("t4_partial", hash_o[39:0], 40'hA5A4A3A2A1);
        timeout_i = 32'd0;

        // Abort at index 40; a RAM write while busy must be dropped.
        txlog.delete();
        pulse_start();
        k = 0;
        while (txlog.size() < 40 && k < 500) begin
            job_wr_i   = (k == 3);
            job_addr_i = 7'd5;
            job_data_i = 8'h77;
            cyc();
            k++;
        end
        job_wr_i = 1'b0;
        abort_i  = 1'b1;
        cyc();
        abort_i  = 1'b0;
        check("t5_busy", busy_o, 0);
        check("t5_txv", tx_valid_o, 0);
        check("t5_sent", txlog.size(), 40);
        txlog.delete();
        pulse_start();
        wait_rx_phase("t5_wait");
        check("t5_ram5", txlog[5], 8'hFA);
        abort_i = 1'b1;
        cyc();
        abort_i = 1'b0;

        // Asynchronous reset mid-receive, then a clean job.
        pulse_start();
        wait_rx_phase("t6_wait");
        for (int b = 0; b < 10; b++) send_rx(8'(8'h50 + b));
        @(negedge clk);
        #3;
        rst_i = 1'b0;
        #1;
        check("t6_busy", busy_o, 0);
        check("t6_hash", hash_o, 0);
        check("t6_done_to", {done_o, timeout_o, tx_valid_o}, 0);
        repeat (2) cyc();
        rst_i = 1'b1;
        cyc();
        pulse_start();
        wait_rx_phase("t6_wait2");
        for (int b = 0; b < 32; b++) send_rx(8'(b * 7 + 3));
        check("t6_done", done_o, 1);
        check("t6_byte0", hash_o[7:0], 8'h03);
        check("t6_byte31", hash_o[255:248], 8'hDC);

        // Randomized traffic against the model.
        for (int c = 0; c < 8000; c++) begin
            if (!busy_o) timeout_i = ($urandom_range(0, 2) == 0) ? 32'd0 : 32'($urandom_range(5, 44));
            tx_ready_i = $urandom_range(0, 1) == 1;
            rx_valid_i = $urandom_range(0, 2) == 0;
            rx_data_i  = 8'($urandom);
            abort_i    = $urandom_range(0, 299) == 0;
            start_i    = $urandom_range(0, 9) == 0;
            job_wr_i   = $urandom_range(0, 3) == 0;
            job_addr_i = 7'($urandom);
            job_data_i = 8'($urandom);
            cyc();
        end
        start_i = 1'b0; abort_i = 1'b0; job_wr_i = 1'b0; rx_valid_i = 1'b0;
        cyc();
        chk_on = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
